// File: rtl/gpio_dim_pkg.sv
// rtl/gpio_dim_pkg.sv - shared duty type, derived pin state and the gamma curve
package gpio_dim_pkg;

   localparam int DUTY_W = 8;

   typedef logic [DUTY_W-1:0] duty_t;

   // Per-pin fade state; never stored, always derived from duty and target
   typedef enum logic [1:0] {
      OFF,
      UP,
      ON,
      DOWN
   } dim_state_t;

   // Classify a pin from its current duty and requested target
   function automatic dim_state_t dim_state(input duty_t duty, input duty_t tgt);
      if (duty < tgt) begin
         return UP;
      end else if (duty > tgt) begin
         return DOWN;
      end else if (duty == '0) begin
         return OFF;
      end else begin
         return ON;
      end
   endfunction

   // Square-law perceptual curve: (d*d) >> 8, so 255 maps to 254 and 1 to 0
   function automatic duty_t gamma_curve(input duty_t d);
      logic [2*DUTY_W-1:0] sq;
      sq = {{DUTY_W{1'b0}}, d} * {{DUTY_W{1'b0}}, d};
      return sq[2*DUTY_W-1:DUTY_W];
   endfunction

endpackage

// File: rtl/gpio_led_dimmer_if.sv
// rtl/gpio_led_dimmer_if.sv - request/brightness inputs and PWM pin outputs of the dimmer
interface gpio_led_dimmer_if #(
   parameter int NPINS = 36
);
   import gpio_dim_pkg::*;

   logic [NPINS-1:0] led_req;
   duty_t            bright;
   logic [NPINS-1:0] gpio;

   // Pattern logic side: issues requests and brightness, observes the pins
   modport master (
      output led_req,
      output bright,
      input  gpio
   );

   // Dimmer side: consumes requests and brightness, drives the pins
   modport slave (
      input  led_req,
      input  bright,
      output gpio
   );

endinterface

// File: rtl/gpio_dim_chan.sv
// rtl/gpio_dim_chan.sv - one-pin duty fader and PWM compare; GPIO_DIM_GAMMA_EN selects square-law duty
module gpio_dim_chan
   import gpio_dim_pkg::*;
(
   input  logic  clk50,
   input  logic  rst,
   input  logic  fade_stb,
   input  logic  led_req,
   input  duty_t bright,
   input  duty_t pwm_cnt,
   output logic  gpio
);

   duty_t      duty;
   duty_t      tgt;
   duty_t      duty_nxt;
   duty_t      duty_eff;
   dim_state_t state;

   // Target, derived fade state, one-step move toward target and compare operand
   always_comb begin
      tgt      = led_req ? bright : '0;
      state    = dim_state(duty, tgt);
      duty_nxt = duty;
      case (state)
         UP:      duty_nxt = duty + duty_t'(1);
         DOWN:    duty_nxt = duty - duty_t'(1);
         default: duty_nxt = duty;
      endcase
`ifdef GPIO_DIM_GAMMA_EN
      duty_eff = gamma_curve(duty);
`else
      duty_eff = duty;
`endif
   end

   // Duty moves only on the fade strobe, which coincides with the frame wrap
   always_ff @(posedge clk50) begin
      if (rst) begin
         duty <= '0;
      end else if (fade_stb) begin
         duty <= duty_nxt;
      end
   end

   // Registered compare; duty 255 still leaves one low slot per frame
   always_ff @(posedge clk50) begin
      if (rst) begin
         gpio <= 1'b0;
      end else begin
         gpio <= (duty_eff > pwm_cnt);
      end
   end

endmodule

// File: rtl/gpio_led_dimmer.sv
// rtl/gpio_led_dimmer.sv - shared PWM timebase and fade strobe feeding one fader per GPIO pin
module gpio_led_dimmer
   import gpio_dim_pkg::*;
#(
   parameter int PWM_DIV     = 195,
   parameter int FADE_FRAMES = 4,
   parameter int NPINS       = 36
) (
   input  logic              clk50,
   input  logic              rst,
   gpio_led_dimmer_if.slave  bus
);

   localparam int PRE_W = (PWM_DIV > 0) ? $clog2(PWM_DIV + 1) : 1;
   localparam int FRM_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

   logic [PRE_W-1:0] pre;
   duty_t            pwm_cnt;
   logic [FRM_W-1:0] frm_cnt;
   logic             tick;
   logic             frame_end;
   logic             fade_stb;
   logic [NPINS-1:0] gpio_q;

   // Tick at the prescaler terminal count, frame end on the pwm wrap tick,
   // fade strobe on the last frame of each fade period
   always_comb begin
      tick      = (pre == PRE_W'(PWM_DIV));
      frame_end = tick && (pwm_cnt == '1);
      fade_stb  = frame_end && (frm_cnt == FRM_W'(FADE_FRAMES - 1));
   end

   // Prescaler: 0..PWM_DIV, one tick per wrap
   always_ff @(posedge clk50) begin
      if (rst) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + PRE_W'(1);
      end
   end

   // PWM slot counter, free-running 0..255 at tick rate
   always_ff @(posedge clk50) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else if (tick) begin
         pwm_cnt <= pwm_cnt + duty_t'(1);
      end
   end

   // Frame counter: counts frame ends 0..FADE_FRAMES-1
   always_ff @(posedge clk50) begin
      if (rst) begin
         frm_cnt <= '0;
      end else if (frame_end) begin
         if (frm_cnt == FRM_W'(FADE_FRAMES - 1)) begin
            frm_cnt <= '0;
         end else begin
            frm_cnt <= frm_cnt + FRM_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NPINS; i++) begin : g_chan
      gpio_dim_chan u_chan (
         .clk50    (clk50),
         .rst      (rst),
         .fade_stb (fade_stb),
         .led_req  (bus.led_req[i]),
         .bright   (bus.bright),
         .pwm_cnt  (pwm_cnt),
         .gpio     (gpio_q[i])
      );
   end

   assign bus.gpio = gpio_q;

endmodule

// File: tb/tb_gpio_led_dimmer.sv
// tb/tb_gpio_led_dimmer.sv - frame-level self-checking bench for gpio_led_dimmer
module tb_gpio_led_dimmer;

   localparam int NP = 36;
   localparam int NC = 4;
   localparam int NA = 14;
   localparam int NB = 12;

   typedef struct {
      int            frames;
      logic [NP-1:0] req;
      logic [7:0]    bright;
      bit            rst_first;
      int            chk_pin;
      int            chk_duty;
   } vec_t;

   logic clk50 = 1'b0;
   logic rst_a;
   logic rst_b;
   logic rst_c;

   int n_cmp = 0;
   int n_bad = 0;

   vec_t tab_a [NA];
   vec_t tab_b [NB];
   int   mdl [2][NP];

   always #5 clk50 = ~clk50;

   gpio_led_dimmer_if #(.NPINS(NP)) bus_a ();
   gpio_led_dimmer_if #(.NPINS(NP)) bus_b ();
   gpio_led_dimmer_if #(.NPINS(NC)) bus_c ();

   gpio_led_dimmer #(.PWM_DIV(0), .FADE_FRAMES(1), .NPINS(NP)) dut_a (
      .clk50 (clk50),
      .rst   (rst_a),
      .bus   (bus_a)
   );

   gpio_led_dimmer #(.PWM_DIV(0), .FADE_FRAMES(1), .NPINS(NP)) dut_b (
      .clk50 (clk50),
      .rst   (rst_b),
      .bus   (bus_b)
   );

   gpio_led_dimmer #(.PWM_DIV(3), .FADE_FRAMES(2), .NPINS(NC)) dut_c (
      .clk50 (clk50),
      .rst   (rst_c),
      .bus   (bus_c)
   );

   // High slots per 256-slot frame for a given duty
   function automatic int eff_ref(input int d);
`ifdef GPIO_DIM_GAMMA_EN
      return (d * d) / 256;
`else
      return d;
`endif
   endfunction

   function automatic logic [NP-1:0] get_gpio(input int lane);
      if (lane == 0) return bus_a.gpio;
      return bus_b.gpio;
   endfunction

   task automatic set_in(input int lane, input logic [NP-1:0] req, input logic [7:0] br);
      if (lane == 0) begin
         bus_a.led_req = req;
         bus_a.bright  = br;
      end else begin
         bus_b.led_req = req;
         bus_b.bright  = br;
      end
   endtask

   // One 256-cycle frame: count highs per pin, compare to the model, then fade the model
   task automatic run_frame(input int lane, input logic [NP-1:0] req, input logic [7:0] br,
                            input int pin, output int pin_cnt);
      int            cnt [NP];
      logic [NP-1:0] g;
      int            bad;
      int            tgt;
      for (int i = 0; i < NP; i++) cnt[i] = 0;
      set_in(lane, req, br);
      repeat (256) begin
         @(posedge clk50);
         #1;
         g = get_gpio(lane);
         for (int i = 0; i < NP; i++) cnt[i] += int'(g[i]);
      end
      bad = -1;
      for (int i = NP - 1; i >= 0; i--) begin
         if (cnt[i] != eff_ref(mdl[lane][i])) bad = i;
      end
      n_cmp++;
      if (bad >= 0) begin
         n_bad++;
         $display("FAIL frame_count lane=%0d pin=%0d high=%0d expected=%0d",
                  lane, bad, cnt[bad], eff_ref(mdl[lane][bad]));
      end
      pin_cnt = 0;
      if (pin >= 0) pin_cnt = cnt[pin];
      for (int i = 0; i < NP; i++) begin
         tgt = req[i] ? int'(br) : 0;
         if (mdl[lane][i] < tgt) mdl[lane][i] = mdl[lane][i] + 1;
         else if (mdl[lane][i] > tgt) mdl[lane][i] = mdl[lane][i] - 1;
      end
   endtask

   // Single-cycle reset in the middle of a frame on dut_b
   task automatic mid_reset_b();
      repeat (100) @(posedge clk50);
      #1;
      n_cmp++;
      if (bus_b.gpio[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset_high got=%b expected=1", bus_b.gpio[0]);
      end
      rst_b = 1'b1;
      @(posedge clk50);
      #1;
      n_cmp++;
      if (bus_b.gpio !== '0) begin
         n_bad++;
         $display("FAIL gpio_after_reset got=%h expected=0", bus_b.gpio);
      end
      rst_b = 1'b0;
      for (int i = 0; i < NP; i++) mdl[1][i] = 0;
   endtask

   task automatic run_lane(input int lane);
      vec_t t;
      int   pc;
      int   n;
      n = (lane == 0) ? NA : NB;
      for (int e = 0; e < n; e++) begin
         t = (lane == 0) ? tab_a[e] : tab_b[e];
         if (t.rst_first) mid_reset_b();
         for (int f = 0; f < t.frames; f++) begin
            run_frame(lane, t.req, t.bright, t.chk_pin, pc);
            if (f == t.frames - 1 && t.chk_pin >= 0) begin
               n_cmp++;
               if (pc != eff_ref(t.chk_duty)) begin
                  n_bad++;
                  $display("FAIL table_point lane=%0d entry=%0d pin=%0d high=%0d expected=%0d",
                           lane, e, t.chk_pin, pc, eff_ref(t.chk_duty));
               end
            end
         end
      end
   endtask

   // PWM_DIV=3, FADE_FRAMES=2: 1024-cycle frames, duty steps every second frame
   task automatic run_lane_c();
      int   c0;
      int   crest;
      int   exp_c;
      int   t0;
      int   t1;
      logic prev;
      for (int m = 0; m < 40; m++) begin
         c0    = 0;
         crest = 0;
         repeat (1024) begin
            @(posedge clk50);
            #1;
            c0    += int'(bus_c.gpio[0]);
            crest += int'(|bus_c.gpio[NC-1:1]);
         end
         exp_c = 4 * eff_ref(m / 2);
         n_cmp++;
         if (c0 != exp_c || crest != 0) begin
            n_bad++;
            $display("FAIL div3_frame window=%0d high=%0d idle_high=%0d expected=%0d/0",
                     m, c0, crest, exp_c);
         end
      end
      prev = bus_c.gpio[0];
      t0   = -1;
      t1   = -1;
      for (int k = 1; k <= 3000 && t1 < 0; k++) begin
         @(posedge clk50);
         #1;
         if (!prev && bus_c.gpio[0]) begin
            if (t0 < 0) t0 = k;
            else t1 = k;
         end
         prev = bus_c.gpio[0];
      end
      n_cmp++;
      if (t0 < 0 || t1 < 0 || (t1 - t0) != 1024) begin
         n_bad++;
         $display("FAIL div3_period got=%0d expected=1024", (t0 < 0 || t1 < 0) ? -1 : t1 - t0);
      end
   endtask

   initial begin
      tab_a[0] = '{8,   36'h0, 8'd255, 1'b0, 1, 0};
      tab_a[1] = '{100, 36'h6, 8'd255, 1'b0, 2, 99};
      tab_a[2] = '{155, 36'h2, 8'd255, 1'b0, 1, 254};
      tab_a[3] = '{4,   36'h2, 8'd255, 1'b0, 1, 255};
      for (int e = 4; e < NA; e++)
         tab_a[e] = '{4, {4'($urandom), 32'($urandom)}, 8'($urandom_range(0, 255)), 1'b0, -1, 0};

      tab_b[0] = '{8,   36'h0, 8'd128, 1'b0, 0, 0};
      tab_b[1] = '{130, 36'h1, 8'd128, 1'b0, 0, 128};
      tab_b[2] = '{30,  36'h1, 8'd100, 1'b0, 0, 100};
      tab_b[3] = '{100, 36'h1, 8'd200, 1'b0, 0, 199};
      tab_b[4] = '{10,  36'h1, 8'd200, 1'b1, 0, 9};
      for (int e = 5; e < NB; e++)
         tab_b[e] = '{4, {4'($urandom), 32'($urandom)}, 8'($urandom_range(0, 255)), 1'b0, -1, 0};

      for (int l = 0; l < 2; l++)
         for (int i = 0; i < NP; i++) mdl[l][i] = 0;

      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      bus_a.led_req = '1;
      bus_a.bright  = 8'hff;
      bus_b.led_req = '1;
      bus_b.bright  = 8'hff;
      bus_c.led_req = 4'b0001;
      bus_c.bright  = 8'hff;

      repeat (4) begin
         @(posedge clk50);
         #1;
         n_cmp++;
         if (bus_a.gpio !== '0 || bus_b.gpio !== '0 || bus_c.gpio !== '0) begin
            n_bad++;
            $display("FAIL reset_hold got=%h/%h/%h expected=0", bus_a.gpio, bus_b.gpio, bus_c.gpio);
         end
      end
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;

      fork
         run_lane(0);
         run_lane(1);
         run_lane_c();
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
